// File: rtl/countdown_sequencer.sv
// Control FSM for a minute/second countdown timer: sequences run/pause/set,
// strobes the down-counter chain and drives a blinking alarm indicator.
module countdown_sequencer #(
  // Number of tick pulses the alarm lasts before returning to READY (1..255).
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        setting,
  input  logic        pb_start,
  input  logic        pb_stop,
  input  logic        zero_min,
  input  logic        zero_sec,
  output logic        cnt_dec,
  output logic        cnt_load,
  output logic        alarm,
  output logic [15:0] led,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StReady = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StSet   = 3'd3,
    StAlarm = 3'd4
  } state_e;

  localparam logic [7:0]  AlarmLimit = 8'(ALARM_TICKS);
  localparam logic [15:0] LedOn      = 16'hFFFF;
  localparam logic [15:0] LedOff     = 16'h0000;

  state_e     state_q;
  logic [7:0] alarm_cnt_q;
  logic       phase_q;
  logic       zero_both;

  assign zero_both = zero_min & zero_sec;
  assign state     = state_q;

  // All outputs are registered alongside the state; every branch assigns the
  // values that belong to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReady;
      cnt_dec     <= 1'b0;
      cnt_load    <= 1'b0;
      alarm       <= 1'b0;
      led         <= LedOff;
      alarm_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      cnt_dec     <= 1'b0;
      cnt_load    <= 1'b0;
      alarm       <= 1'b0;
      led         <= LedOff;
      alarm_cnt_q <= 8'd0;
      phase_q     <= 1'b0;

      if (setting) begin
        state_q <= StSet;
      end else begin
        case (state_q)
          StReady: begin
            if (pb_stop) begin
              state_q  <= StReady;
              cnt_load <= 1'b1;
            end else if (pb_start) begin
              if (zero_both) begin
                state_q <= StAlarm;
                alarm   <= 1'b1;
                led     <= LedOn;
                phase_q <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end
          end

          StRun: begin
            if (pb_stop) begin
              state_q  <= StReady;
              cnt_load <= 1'b1;
            end else if (zero_both) begin
              // Counter already at 00:00, so no decrement on the way out.
              state_q <= StAlarm;
              alarm   <= 1'b1;
              led     <= LedOn;
              phase_q <= 1'b1;
            end else begin
              cnt_dec <= tick;
              if (pb_start) begin
                state_q <= StPause;
              end
            end
          end

          StPause: begin
            if (pb_stop) begin
              state_q  <= StReady;
              cnt_load <= 1'b1;
            end else if (pb_start) begin
              state_q <= StRun;
            end
          end

          StSet: begin
            state_q  <= StReady;
            cnt_load <= 1'b1;
          end

          StAlarm: begin
            if (pb_stop || pb_start) begin
              state_q  <= StReady;
              cnt_load <= 1'b1;
            end else if (tick && (alarm_cnt_q + 8'd1 == AlarmLimit)) begin
              state_q  <= StReady;
              cnt_load <= 1'b1;
            end else if (tick) begin
              alarm_cnt_q <= alarm_cnt_q + 8'd1;
              phase_q     <= ~phase_q;
              alarm       <= 1'b1;
              led         <= phase_q ? LedOff : LedOn;
            end else begin
              alarm_cnt_q <= alarm_cnt_q;
              phase_q     <= phase_q;
              alarm       <= 1'b1;
              led         <= phase_q ? LedOn : LedOff;
            end
          end

          // Unused encodings recover to READY with a reload.
          default: begin
            state_q  <= StReady;
            cnt_load <= 1'b1;
          end
        endcase
      end
    end
  end

  a_dec_load_excl : assert property (@(posedge clk) disable iff (rst) !(cnt_dec && cnt_load));
  a_alarm_state : assert property (@(posedge clk) disable iff (rst) alarm == (state_q == StAlarm));
  a_led_idle : assert property (@(posedge clk) disable iff (rst) alarm || (led == LedOff));

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer; a monitor checks every strobe
// against expectations queued by the stimulus process.
module tb_countdown_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        setting = 1'b0;
  logic        pb_start = 1'b0;
  logic        pb_stop = 1'b0;
  logic        zero_min = 1'b0;
  logic        zero_sec = 1'b0;
  logic        cnt_dec;
  logic        cnt_load;
  logic        alarm;
  logic [15:0] led;
  logic [2:0]  state;

  localparam logic [2:0] SReady = 3'd0;
  localparam logic [2:0] SRun   = 3'd1;
  localparam logic [2:0] SPause = 3'd2;
  localparam logic [2:0] SSet   = 3'd3;
  localparam logic [2:0] SAlarm = 3'd4;

  typedef struct packed {
    logic       is_dec;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  countdown_sequencer #(.ALARM_TICKS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .setting  (setting),
    .pb_start (pb_start),
    .pb_stop  (pb_stop),
    .zero_min (zero_min),
    .zero_sec (zero_sec),
    .cnt_dec  (cnt_dec),
    .cnt_load (cnt_load),
    .alarm    (alarm),
    .led      (led),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic is_dec, input logic [2:0] st);
    exp_t e;
    e.is_dec = is_dec;
    e.st     = st;
    exp_q.push_back(e);
  endtask

  // One clock cycle of pulse inputs; returns just after the rising edge.
  task automatic cyc(input logic t, input logic st, input logic sp);
    @(negedge clk);
    tick     = t;
    pb_start = st;
    pb_stop  = sp;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (cnt_dec || cnt_load)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: dec=%0b load=%0b state=%0d, none expected at %0t",
                   cnt_dec, cnt_load, state, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cnt_dec !== e.is_dec || cnt_load !== !e.is_dec || state !== e.st) begin
            failures++;
            $display("FAIL strobe: dec=%0b load=%0b state=%0d expected dec=%0b load=%0b state=%0d at %0t",
                     cnt_dec, cnt_load, state, e.is_dec, !e.is_dec, e.st, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'(SReady));
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_alarm", 32'(alarm), 32'h0);
    chk("reset_strobes", {30'b0, cnt_dec, cnt_load}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Start and three aligned decrements.
    cyc(0, 1, 0);
    chk("start_run", 32'(state), 32'(SRun));
    for (int i = 0; i < 3; i++) begin
      expect_ev(1'b1, SRun);
      cyc(1, 0, 0);
      chk("run_dec_pulse", 32'(cnt_dec), 32'h1);
      cyc(0, 0, 0);
    end
    chk("run_after_ticks", 32'(state), 32'(SRun));

    // Pause swallows ticks, resume decrements again.
    cyc(0, 1, 0);
    chk("pause", 32'(state), 32'(SPause));
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("pause_hold", 32'(state), 32'(SPause));
    cyc(0, 1, 0);
    chk("resume", 32'(state), 32'(SRun));
    expect_ev(1'b1, SRun);
    cyc(1, 0, 0);
    // Tick coincident with pause still decrements.
    expect_ev(1'b1, SPause);
    cyc(1, 1, 0);
    chk("tick_pause", 32'(state), 32'(SPause));
    cyc(0, 1, 0);

    // Setting outranks stop; leaving SET reloads once.
    setting = 1'b1;
    cyc(0, 0, 1);
    chk("set_over_stop", 32'(state), 32'(SSet));
    chk("set_no_load", 32'(cnt_load), 32'h0);
    cyc(1, 0, 0);
    setting = 1'b0;
    expect_ev(1'b0, SReady);
    cyc(0, 0, 0);
    chk("set_exit", 32'(state), 32'(SReady));

    // Reaching zero while running: alarm, blink, auto-return after 10 ticks.
    cyc(0, 1, 0);
    zero_min = 1'b1;
    zero_sec = 1'b1;
    cyc(1, 0, 0);
    chk("zero_alarm", 32'(state), 32'(SAlarm));
    chk("zero_alarm_flag", 32'(alarm), 32'h1);
    chk("zero_led_on", 32'(led), 32'hFFFF);
    chk("zero_no_dec", 32'(cnt_dec), 32'h0);
    cyc(1, 0, 0);
    chk("blink_off", 32'(led), 32'h0);
    cyc(1, 0, 0);
    chk("blink_on", 32'(led), 32'hFFFF);
    cyc(0, 0, 0);
    chk("blink_hold", 32'(led), 32'hFFFF);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0);
    chk("alarm_tick9", 32'(state), 32'(SAlarm));
    chk("alarm_tick9_led", 32'(led), 32'h0);
    expect_ev(1'b0, SReady);
    cyc(1, 0, 0);
    chk("alarm_timeout", 32'(state), 32'(SReady));
    chk("alarm_timeout_flag", 32'(alarm), 32'h0);

    // Start at zero goes straight to alarm; stop leaves it.
    cyc(0, 1, 0);
    chk("ready_zero_alarm", 32'(state), 32'(SAlarm));
    chk("ready_zero_led", 32'(led), 32'hFFFF);
    expect_ev(1'b0, SReady);
    cyc(0, 0, 1);
    chk("alarm_stop", 32'(state), 32'(SReady));
    chk("alarm_stop_led", 32'(led), 32'h0);

    // Asynchronous reset between edges during alarm.
    cyc(0, 1, 0);
    chk("alarm_again", 32'(state), 32'(SAlarm));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'(SReady));
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_alarm", 32'(alarm), 32'h0);
    @(negedge clk);
    tick = 1'b0;
    pb_start = 1'b0;
    pb_stop = 1'b0;
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("post_rst_ready", 32'(state), 32'(SReady));
    chk("post_rst_no_load", 32'(cnt_load), 32'h0);

    // Stop from RUN (tick ignored), READY and PAUSE.
    zero_min = 1'b0;
    zero_sec = 1'b0;
    cyc(0, 1, 0);
    expect_ev(1'b0, SReady);
    cyc(1, 0, 1);
    chk("run_stop", 32'(state), 32'(SReady));
    chk("run_stop_no_dec", 32'(cnt_dec), 32'h0);
    expect_ev(1'b0, SReady);
    cyc(0, 0, 1);
    chk("ready_stop", 32'(cnt_load), 32'h1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("pause2", 32'(state), 32'(SPause));
    expect_ev(1'b0, SReady);
    cyc(0, 0, 1);
    chk("pause_stop", 32'(state), 32'(SReady));

    // Start request also ends an alarm.
    zero_min = 1'b1;
    zero_sec = 1'b1;
    cyc(0, 1, 0);
    expect_ev(1'b0, SReady);
    cyc(0, 1, 0);
    chk("alarm_start_exit", 32'(state), 32'(SReady));

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
